// File: rtl/weight_load_sched_if.sv
// Weight stream handshake: one WEIGHT_WIDTH beat per cycle, lane 0 first, valid/ready.
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif

interface weight_load_sched_if #(
    parameter int WEIGHT_WIDTH = `WEIGHT_WIDTH
);
    logic                    wt_valid;
    logic [WEIGHT_WIDTH-1:0] wt_data;
    logic                    wt_ready;

    modport master (output wt_valid, output wt_data, input  wt_ready);
    modport slave  (input  wt_valid, input  wt_data, output wt_ready);
endinterface

// File: rtl/weight_load_sched.sv
// Stages weight beats into a DIM_C-lane buffer and commits sets to w_out; first compute DIM_C+2 cycles after start.
// Stream backpressure: wt_ready drops while a full set waits for commit, and once every set has been fetched.
`ifndef DIM_C
`define DIM_C 4
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 8
`endif

module weight_load_sched #(
    parameter int DIM_C        = `DIM_C,
    parameter int WEIGHT_WIDTH = `WEIGHT_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [15:0]                          num_tiles,
    input  logic [15:0]                          tile_len,
    weight_load_sched_if.slave                   wt,
    output logic [DIM_C-1:0][WEIGHT_WIDTH-1:0]   w_out,
    output logic                                 w_commit,
    output logic                                 compute_en,
    output logic                                 busy,
    output logic                                 done
);
    localparam int LW = (DIM_C > 1) ? $clog2(DIM_C) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_STALL, S_DONE} state_t;

    state_t state, state_nxt;
    logic [15:0] nt, tl;
    logic [15:0] lane_cnt, fetched, tiles_done, cyc_cnt;
    logic [DIM_C-1:0][WEIGHT_WIDTH-1:0] stage;
    logic stage_full;
    logic commit, last_cyc, final_tile, accept;

    // 17-bit compares so tl/nt near 16'hFFFF never wrap
    assign last_cyc   = ({1'b0, cyc_cnt} + 17'd1) == {1'b0, tl};
    assign final_tile = ({1'b0, tiles_done} + 17'd1) == {1'b0, nt};
    assign accept     = wt.wt_valid & wt.wt_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (num_tiles != 16'd0 && tile_len != 16'd0) state_nxt = S_FILL;
                    else                                         state_nxt = S_DONE;
                end
            end
            S_FILL, S_STALL: begin
                if (stage_full) begin
                    commit    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (last_cyc) begin
                    if (final_tile)      state_nxt = S_DONE;
                    else if (stage_full) commit    = 1'b1;
                    else                 state_nxt = S_STALL;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        compute_en  = (state == S_RUN);
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        wt.wt_ready = (state == S_FILL || state == S_RUN || state == S_STALL)
                      && !stage_full && (fetched < nt);
    end

    // accept needs !stage_full and commit needs stage_full, so they never collide
    always_ff @(posedge clk) begin
        if (rst) begin
            nt         <= '0;
            tl         <= '0;
            lane_cnt   <= '0;
            fetched    <= '0;
            tiles_done <= '0;
            cyc_cnt    <= '0;
            stage      <= '0;
            stage_full <= 1'b0;
            w_out      <= '0;
            w_commit   <= 1'b0;
        end else begin
            w_commit <= commit;
            if (state == S_IDLE && start) begin
                nt         <= num_tiles;
                tl         <= tile_len;
                lane_cnt   <= '0;
                fetched    <= '0;
                tiles_done <= '0;
                cyc_cnt    <= '0;
                stage_full <= 1'b0;
            end else begin
                if (accept) begin
                    stage[lane_cnt[LW-1:0]] <= wt.wt_data;
                    if (lane_cnt == 16'(DIM_C - 1)) begin
                        lane_cnt   <= '0;
                        stage_full <= 1'b1;
                        fetched    <= fetched + 16'd1;
                    end else begin
                        lane_cnt <= lane_cnt + 16'd1;
                    end
                end
                if (commit) begin
                    w_out      <= stage;
                    stage_full <= 1'b0;
                    cyc_cnt    <= '0;
                end else if (state == S_RUN) begin
                    cyc_cnt <= cyc_cnt + 16'd1;
                end
                if (state == S_RUN && last_cyc) tiles_done <= tiles_done + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_weight_load_sched.sv
// Randomized scoreboard bench for weight_load_sched: tile timing predicted from per-tile fill/compute arithmetic.
module tb_weight_load_sched;
    localparam int DIM_C = 4;
    localparam int WW    = 8;
    localparam int MAXC  = 1024;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [15:0] num_tiles = '0, tile_len = '0;
    logic [DIM_C-1:0][WW-1:0] w_out;
    logic w_commit, compute_en, busy, done;

    weight_load_sched_if #(.WEIGHT_WIDTH(WW)) wt_if ();

    weight_load_sched #(.DIM_C(DIM_C), .WEIGHT_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles), .tile_len(tile_len),
        .wt(wt_if), .w_out(w_out), .w_commit(w_commit), .compute_en(compute_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int n_checks = 0, n_pass = 0;
    int exp_commit_cyc[$];
    logic [DIM_C*WW-1:0] exp_commit_set[$];
    int exp_ce[$];
    int exp_done[$];
    logic [WW-1:0] dq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, gcyc);
    endtask

    // Monitor: pops an expectation whenever the DUT shows an event
    always @(negedge clk) begin
        if (!rst) begin
            if (w_commit) begin
                if (exp_commit_cyc.size() == 0) check("unexpected_commit", 64'(gcyc), 64'(-1));
                else begin
                    check("commit_cycle", 64'(gcyc), 64'(exp_commit_cyc.pop_front()));
                    check("commit_wout", 64'(w_out), 64'(exp_commit_set.pop_front()));
                end
            end
            if (compute_en) begin
                if (exp_ce.size() == 0) check("unexpected_compute", 64'(gcyc), 64'(-1));
                else check("compute_cycle", 64'(gcyc), 64'(exp_ce.pop_front()));
            end
            if (done) begin
                if (exp_done.size() == 0) check("unexpected_done", 64'(gcyc), 64'(-1));
                else check("done_cycle", 64'(gcyc), 64'(exp_done.pop_front()));
            end
        end
    end

    task automatic clear_exp();
        exp_commit_cyc.delete();
        exp_commit_set.delete();
        exp_ce.delete();
        exp_done.delete();
    endtask

    // mode 0: valid always high, 1: 1,0,0,1,1,0,1 repeated, 2: random
    task automatic run(input int nt, input int tl, input int mode, input bit directed,
                       input bit poke, input int abort_rel);
        logic vpat [MAXC];
        bit   pat [7];
        int   s_cyc [16];
        int   t0, d, c, cnt, f, ptr, exp_beats;
        logic [DIM_C*WW-1:0] set;

        pat = '{1, 0, 0, 1, 1, 0, 1};
        dq.delete();
        for (int i = 0; i < nt * DIM_C; i++)
            dq.push_back(directed ? WW'(8'h11 * (i + 1)) : WW'($urandom));
        vpat[0] = 1'b0;
        for (int i = 1; i < MAXC; i++) begin
            case (mode)
                0:       vpat[i] = 1'b1;
                1:       vpat[i] = pat[(i - 1) % 7];
                default: vpat[i] = ($urandom_range(0, 2) != 0);
            endcase
        end

        @(posedge clk); #1;
        t0 = gcyc;
        start = 1'b1; num_tiles = 16'(nt); tile_len = 16'(tl);
        wt_if.wt_valid = 1'b0;

        // Reference: set k may load from the cycle set k-1 starts computing;
        // it computes from max(previous tile end, its own fill + 2) for tl cycles.
        if (nt == 0 || tl == 0) begin
            d = 1;
            exp_beats = 0;
        end else begin
            exp_beats = nt * DIM_C;
            for (int k = 0; k < nt; k++) begin
                c = (k == 0) ? 1 : s_cyc[k - 1];
                cnt = 0;
                while (c < MAXC - 1) begin
                    if (vpat[c]) begin
                        cnt++;
                        if (cnt == DIM_C) break;
                    end
                    c++;
                end
                f = c;
                s_cyc[k] = f + 2;
                if (k > 0 && s_cyc[k - 1] + tl > s_cyc[k]) s_cyc[k] = s_cyc[k - 1] + tl;
                set = '0;
                for (int j = 0; j < DIM_C; j++) set[j*WW +: WW] = dq[k*DIM_C + j];
                exp_commit_cyc.push_back(t0 + s_cyc[k]);
                exp_commit_set.push_back(set);
                for (int i = 0; i < tl; i++) exp_ce.push_back(t0 + s_cyc[k] + i);
            end
            d = s_cyc[nt - 1] + tl;
        end
        exp_done.push_back(t0 + d);

        ptr = 0;
        for (int rel = 0; rel <= d + 1; rel++) begin
            if (rel > 0) begin
                @(posedge clk); #1;
                start = poke && (rel == 3);
                if (start) begin
                    num_tiles = 16'($urandom);
                    tile_len  = 16'($urandom);
                end
            end
            wt_if.wt_valid = vpat[rel];
            wt_if.wt_data  = (ptr < dq.size()) ? dq[ptr] : WW'($urandom);
            if (rel == abort_rel) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                wt_if.wt_valid = 1'b0;
                clear_exp();
                @(negedge clk);
                check("abort_wout", 64'(w_out), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                check("abort_compute_en", 64'(compute_en), 64'd0);
                check("abort_wt_ready", 64'(wt_if.wt_ready), 64'd0);
                return;
            end
            @(negedge clk);
            if (wt_if.wt_valid && wt_if.wt_ready) ptr++;
            if (rel == d) check("busy_in_done", 64'(busy), 64'd1);
            if (rel == d + 1) begin
                check("idle_busy", 64'(busy), 64'd0);
                check("idle_wt_ready", 64'(wt_if.wt_ready), 64'd0);
            end
        end
        @(posedge clk); #1;
        wt_if.wt_valid = 1'b0;
        check("beats_accepted", 64'(ptr), 64'(exp_beats));
        check("commit_q_empty", 64'(exp_commit_cyc.size()), 64'd0);
        check("compute_q_empty", 64'(exp_ce.size()), 64'd0);
        check("done_q_empty", 64'(exp_done.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", gcyc);
        $fatal(1);
    end

    initial begin
        wt_if.wt_valid = 1'b0;
        wt_if.wt_data  = '0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            start = 1'($urandom); num_tiles = 16'($urandom); tile_len = 16'($urandom);
            wt_if.wt_valid = 1'($urandom); wt_if.wt_data = WW'($urandom);
            @(negedge clk);
            check("rst_wout", 64'(w_out), 64'd0);
            check("rst_w_commit", 64'(w_commit), 64'd0);
            check("rst_compute_en", 64'(compute_en), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_wt_ready", 64'(wt_if.wt_ready), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; wt_if.wt_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        run(1, 3, 0, 1'b1, 1'b0, -1);
        run(3, 5, 0, 1'b0, 1'b0, -1);
        run(2, 2, 0, 1'b0, 1'b0, -1);
        run(3, 3, 1, 1'b0, 1'b0, -1);
        run(0, 4, 0, 1'b0, 1'b0, -1);
        run(2, 0, 0, 1'b0, 1'b0, -1);
        run(2, 3, 0, 1'b0, 1'b1, -1);
        run(2, 20, 0, 1'b0, 1'b0, 12);
        run(1, 3, 0, 1'b1, 1'b0, -1);
        for (int i = 0; i < 10; i++)
            run($urandom_range(1, 4), $urandom_range(1, 8), $urandom_range(0, 2),
                1'b0, 1'($urandom_range(0, 1)), -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
